// File: rtl/fetch_queue_if.sv
// Fetch-stage handshake bundle.
//   imem_req_*  : fetch request to a 1-cycle-latency instruction memory
//   imem_resp_* : read data returning one cycle after an accepted request
//   redirect_*  : flush-and-restart from a taken branch or jump
//   dec_*       : head instruction, PC and opcode presented to decode
// master: the fetch queue; slave: the memory/decode/branch environment.
interface fetch_queue_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_instr, dec_pc, dec_opcode,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_instr, dec_pc, dec_opcode,
        output dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue feeding decode.
// Issues sequential word-aligned fetch addresses to a 1-cycle-latency
// instruction memory, buffers returned words with their PCs in a DEPTH-entry
// FIFO and presents the head entry (instr, pc, opcode) to decode. A redirect
// flushes buffered and in-flight fetches and restarts at the new PC.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   fq    : fetch_queue_if.master (imem request/response, redirect, decode)
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : FIFO entries, power of two, >= 2
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.master fq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fpc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [CNT_W:0] used;
    logic           req_valid;
    logic           accept;
    logic           push;
    logic           pop;
    logic           not_empty;

    // Credit rule: buffered entries plus the outstanding request may never
    // exceed the FIFO, so a returning response always has a free slot.
    always_comb begin
        used      = {1'b0, count} + (CNT_W + 1)'(inflight);
        not_empty = (count != '0);
        req_valid = !reset && !fq.redirect_valid && (used < DEPTH_W);
        accept    = req_valid && fq.imem_req_ready;
        push      = fq.imem_resp_valid && !fq.redirect_valid;
        pop       = not_empty && fq.dec_ready && !fq.redirect_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc      <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (fq.redirect_valid) begin
            // Redirect discards everything: buffered entries, the pending
            // response and any concurrent decode handshake.
            fpc      <= fq.redirect_pc & ~32'h3;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                fpc      <= fpc + 32'd4;
                req_pc   <= fpc;
                inflight <= 1'b1;
            end else if (fq.imem_resp_valid) begin
                inflight <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only visible when count != 0.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= fq.imem_resp_data;
        end
    end

    always_comb begin
        fq.imem_req_valid = req_valid;
        fq.imem_req_addr  = fpc;
        fq.dec_valid      = not_empty;
        fq.dec_instr      = NOP;
        fq.dec_pc         = '0;
        if (not_empty) begin
            fq.dec_instr = instr_mem[rd_ptr];
            fq.dec_pc    = pc_mem[rd_ptr];
        end
        fq.dec_opcode = fq.dec_instr[6:0];
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clock;
    logic reset;
    fetch_queue_if f();

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .fq    (f)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Expected decode stream (program order) and expected fetch address.
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int unsigned n_acc;
    logic [31:0] last_acc;
    bit          acc_now;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2C5A_0F13;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Instruction memory: answers every accepted request one cycle later.
    initial begin : memory
        bit          acc;
        logic [31:0] a;
        f.imem_resp_valid = 1'b0;
        f.imem_resp_data  = '0;
        forever begin
            @(negedge clock);
            acc = f.imem_req_valid && f.imem_req_ready;
            a   = f.imem_req_addr;
            @(posedge clock);
            #1;
            f.imem_resp_valid = acc;
            f.imem_resp_data  = mem_word(a);
        end
    end

    // One cycle of stimulus: drive inputs after the edge, update the
    // reference model, then record/check any request accepted this cycle.
    task automatic cycle(input logic rst, input logic rd, input logic rr,
                         input logic redir, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset            = rst;
        f.dec_ready      = rd;
        f.imem_req_ready = rr;
        f.redirect_valid = redir;
        f.redirect_pc    = rpc;
        if (rst) begin
            exp_q.delete();
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else if (redir) begin
            exp_q.delete();
            exp_pc  = rpc & ~32'h3;
            exp_req = rpc & ~32'h3;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc += 32'd4;
        end
        #1;
        acc_now = f.imem_req_valid && f.imem_req_ready;
        if (acc_now) begin
            chk("req_addr", f.imem_req_addr, exp_req);
            last_acc = f.imem_req_addr;
            exp_req += 32'd4;
            n_acc++;
        end
    endtask

    // Monitor: checks decode outputs every cycle and pops the scoreboard on
    // each decode handshake. Occupancy is tracked from observed handshakes.
    initial begin : monitor
        int unsigned count_tb = 0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_pc, prev_instr;
        bit          push_m, pop_m;
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (!f.dec_valid) begin
                    chk("empty_instr", f.dec_instr, NOP);
                    chk("empty_pc", f.dec_pc, 32'h0);
                    chk("empty_opcode", {25'h0, f.dec_opcode}, 32'h13);
                end else begin
                    chk("opcode", {25'h0, f.dec_opcode}, {25'h0, f.dec_instr[6:0]});
                end
                chk("dec_valid", {31'h0, f.dec_valid}, {31'h0, count_tb != 0});
                if (prev_hold && !reset) begin
                    chk("hold_pc", f.dec_pc, prev_pc);
                    chk("hold_instr", f.dec_instr, prev_instr);
                end
                push_m = !reset && !f.redirect_valid && f.imem_resp_valid;
                pop_m  = !reset && !f.redirect_valid && (count_tb != 0) && f.dec_ready;
                if (push_m)
                    chk("no_overflow", {31'h0, count_tb == DEPTH}, 32'h0);
                if (pop_m) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL dec_stream: pop with empty expected queue");
                    end else begin
                        e = exp_q.pop_front();
                        chk("dec_pc", f.dec_pc, e[63:32]);
                        chk("dec_instr", f.dec_instr, e[31:0]);
                    end
                end
                if (reset || f.redirect_valid)
                    count_tb = 0;
                else
                    count_tb = count_tb + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
                prev_hold  = !reset && !f.redirect_valid && f.dec_valid && !f.dec_ready;
                prev_pc    = f.dec_pc;
                prev_instr = f.dec_instr;
            end
        end
    end

    initial begin : driver
        logic [31:0] wrap_list [4];
        int unsigned idx;
        reset            = 1'b1;
        f.dec_ready      = 1'b1;
        f.imem_req_ready = 1'b1;
        f.redirect_valid = 1'b0;
        f.redirect_pc    = '0;

        // Reset, including a redirect that reset must override.
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        mon_en = 1'b1;
        chk("rst_req_valid", {31'h0, f.imem_req_valid}, 32'h0);
        chk("rst_dec_valid", {31'h0, f.dec_valid}, 32'h0);
        chk("rst_dec_instr", f.dec_instr, NOP);
        cycle(1, 1, 1, 1, 32'h0000_4000);
        chk("rst_redirect_req", {31'h0, f.imem_req_valid}, 32'h0);

        // Reset release: back-to-back requests, 2-cycle fetch-to-decode.
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 1, 0, 0);
            chk("boot_req_valid", {31'h0, f.imem_req_valid}, 32'h1);
            chk("boot_req_addr", f.imem_req_addr, RESET_PC + 32'(4 * k));
            if (k >= 2) chk("boot_dec_pc", f.dec_pc, RESET_PC + 32'(4 * (k - 2)));
        end

        // Decode stall: restart at 0x100 with dec_ready low for 10 cycles.
        cycle(0, 0, 1, 1, 32'h0000_0100);
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 1, 0, 0);
            if (f.dec_valid) chk("stall_dec_pc", f.dec_pc, 32'h0000_0100);
        end
        chk("stall_accepts", n_acc, 4);
        chk("stall_req_valid", {31'h0, f.imem_req_valid}, 32'h0);
        n_acc = 0;
        for (int t = 0; t < 20 && n_acc == 0; t++) cycle(0, 1, 1, 0, 0);
        chk("resume_seen", n_acc, 1);
        chk("resume_addr", last_acc, 32'h0000_0110);

        // Fill to 3 entries + 1 in flight, then redirect with dec_ready and
        // a response arriving in the same cycle.
        cycle(0, 0, 1, 1, 32'h0000_0300);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 0);
        chk("fill_dec_valid", {31'h0, f.dec_valid}, 32'h1);
        cycle(0, 1, 1, 1, 32'h0000_2002);
        chk("redir_resp_present", {31'h0, f.imem_resp_valid}, 32'h1);
        cycle(0, 1, 1, 0, 0);
        chk("redir_n1_dec_valid", {31'h0, f.dec_valid}, 32'h0);
        chk("redir_n1_req_valid", {31'h0, f.imem_req_valid}, 32'h1);
        chk("redir_n1_req_addr", f.imem_req_addr, 32'h0000_2000);
        cycle(0, 1, 1, 0, 0);
        chk("redir_n2_dec_valid", {31'h0, f.dec_valid}, 32'h0);
        cycle(0, 1, 1, 0, 0);
        chk("redir_n3_dec_valid", {31'h0, f.dec_valid}, 32'h1);
        chk("redir_n3_dec_pc", f.dec_pc, 32'h0000_2000);

        // Address wrap under a randomly stalling memory.
        wrap_list = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
        idx = 0;
        for (int t = 0; t < 200 && idx < 4; t++) begin
            cycle(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), 0, 0);
            if (acc_now) begin
                chk("wrap_addr", last_acc, wrap_list[idx]);
                idx++;
            end
        end
        chk("wrap_seen", idx, 4);

        // Random traffic with occasional redirects.
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 39) == 0)
                cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom);
            else
                cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 0, 0);
        end
        for (int t = 0; t < 10; t++) cycle(0, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
